mas_prog_loader: RTL and testbench
==================================

Name: mas_prog_loader

Overview:
Serial program loader that sits directly upstream of the MAS8 processor core. It receives a bit-serial program image (a header word followed by N 16-bit instructions) and presents each instruction on the core's 16-bit instruction input. For each word it asserts the core's program-mode and enable strobes for one cycle, then releases the core into run mode. It is the only driver of the core's instr_in, pr and en inputs.

Parameters:
SYNC, 8'hA5, required value of header bits [15:8].

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rstz  input  1  asynchronous active-low reset.
dvdd  inout  1  digital supply, pass-through.
dgnd  inout  1  digital ground, pass-through.
start  input  1  begin a load; honoured only in IDLE, RUN and ERR.
sdi  input  1  serial data bit, MSB first.
sval  input  1  sdi is valid this cycle; sampled at the rising edge of clk.
run_en  input  1  core enable request while in RUN.
instr  output  16  instruction word to the core's instr_in.
pr  output  1  program-mode strobe to the core.
en  output  1  enable to the core.
busy  output  1  high in HDR, LOAD and WRITE.
done  output  1  high in RUN.
err  output  1  high in ERR.
wcnt  output  8  low 8 bits of the count of words written in the current load.

Behaviour:
- All outputs are registered or decoded from state; there are no combinational paths from inputs to outputs.

Reset:
- rstz=0 forces state IDLE asynchronously.
- instr=0, pr=0, en=0, busy=0, done=0, err=0, wcnt=0.
- Shift register, bit counter and stored N are cleared.

Shift path:
- Every edge with sval=1 shifts in sdi: shreg <= {shreg[14:0], sdi}; the 4-bit bit counter increments.
- A bit counter value of 15 together with sval=1 marks a word-complete event; the bit counter then wraps to 0.
- Shifting is active in HDR, LOAD and WRITE. In all other states the bit counter is held at 0.

States:
- IDLE: pr=0, en=0.
  - start=1 -> HDR; clears wcnt, err and the bit counter.
- HDR: pr=0, en=0.
  - On word-complete, the word is {shreg[14:0], sdi}.
  - If word[15:8]==SYNC: store nm1=word[7:0] (N=nm1+1, so N ranges 1..256) and go to LOAD.
  - Otherwise go to ERR.
- LOAD: pr=1, en=0.
  - On word-complete: instr <= {shreg[14:0], sdi} and go to WRITE.
- WRITE: exactly one cycle, pr=1, en=1; the core captures instr during this cycle.
  - At the end of the cycle wcnt increments (9-bit internal counter).
  - If the pre-increment count equals nm1, go to RUN; otherwise go to LOAD.
  - Bits with sval=1 during WRITE are shifted normally, so back-to-back serial words lose no bits.
- RUN: pr=0, en=run_en (registered, 1-cycle latency), done=1.
  - instr holds the last loaded word.
  - start=1 -> HDR, which reloads the program; done drops the next cycle.
- ERR: pr=0, en=0, err=1.
  - start=1 -> HDR; clears err.

Rules:
- start is ignored in HDR, LOAD and WRITE.
- Latency: the edge that samples bit 16 of an instruction moves the block to WRITE; pr=1 and en=1 are visible in the following cycle.
- Minimum spacing between WRITE strobes is 16 cycles (sval continuously high).
- Reset mid-load aborts immediately. The core sees pr=0 and en=0 asynchronously, and a partially shifted word is discarded.
- wcnt wraps from 255 to 0 on the 256th write. The RUN transition uses the internal 9-bit count, so N=256 completes correctly.

Test Plan:
- Header 16'hA502 then words 16'h1234, 16'h9C05, 16'hF0FF with sval continuously high -> three single-cycle pr=1/en=1 pulses carrying those values, spaced 16 cycles apart; then RUN, done=1, wcnt=3, instr=16'hF0FF.
- Header 16'h5A00 -> ERR, err=1, pr=0, en=0, no WRITE pulse. A following start and a valid header 16'hA500 plus one word -> err clears, one write, RUN.
- Header 16'hA500, then a word sent with sval gaps (one bit every 3 cycles) -> exactly one write carrying the correct word; bit counter unaffected by the gaps.
- rstz pulsed low after 8 bits of the second word of a 4-word load -> all outputs 0 immediately. After start and a fresh full load -> wcnt=4, RUN.
- Header 16'hA5FF plus 256 words -> 256 write pulses, wcnt=0 in RUN, done=1. start and run_en toggled during LOAD have no effect.
- In RUN, run_en 0->1->0 -> en follows one cycle later. start in RUN -> busy=1 and done=0 the next cycle; a new load proceeds normally.

Source files
------------

// File: rtl/mas_prog_loader.sv
// Serial program loader for the MAS8 core: checks a sync header, then shifts in
// N 16-bit instructions and strobes each one into the core before releasing it to run.
module mas_prog_loader #(
  parameter logic [7:0] SYNC = 8'hA5
) (
  input  logic        clk,
  input  logic        rstz,
  inout  wire         dvdd,
  inout  wire         dgnd,
  input  logic        start,
  input  logic        sdi,
  input  logic        sval,
  input  logic        run_en,
  output logic [15:0] instr,
  output logic        pr,
  output logic        en,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  wcnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    LOAD  = 3'd2,
    WRITE = 3'd3,
    RUN   = 3'd4,
    ERR   = 3'd5
  } state_t;

  state_t      state;
  logic [14:0] shreg;
  logic [3:0]  bcnt;
  logic [7:0]  nm1;
  logic [8:0]  cnt;
  logic        shift_on;
  logic        word_done;
  logic [15:0] word;
  logic        unused_supply;

  // Supplies pass through untouched; they carry no logic function here.
  assign unused_supply = dvdd ^ dgnd;

  assign shift_on  = (state == HDR) || (state == LOAD) || (state == WRITE);
  assign word_done = shift_on && sval && (bcnt == 4'd15);
  assign word      = {shreg, sdi};
  assign wcnt      = cnt[7:0];

  // Shifting continues through WRITE so back-to-back words lose no bits.
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      shreg <= '0;
      bcnt  <= '0;
    end else if (shift_on) begin
      if (sval) begin
        shreg <= {shreg[13:0], sdi};
        bcnt  <= bcnt + 4'd1;
      end
    end else begin
      bcnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state <= IDLE;
      instr <= '0;
      pr    <= 1'b0;
      en    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      nm1   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE, RUN, ERR: begin
          if (start) begin
            state <= HDR;
            cnt   <= '0;
            err   <= 1'b0;
            busy  <= 1'b1;
            done  <= 1'b0;
            en    <= 1'b0;
          end else if (state == RUN) begin
            en <= run_en;
          end
        end
        HDR: begin
          if (word_done) begin
            if (word[15:8] == SYNC) begin
              nm1   <= word[7:0];
              state <= LOAD;
              pr    <= 1'b1;
            end else begin
              state <= ERR;
              busy  <= 1'b0;
              err   <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (word_done) begin
            instr <= word;
            state <= WRITE;
            en    <= 1'b1;
          end
        end
        WRITE: begin
          // 9-bit count so that N=256 (nm1=255) still terminates after the last write.
          cnt <= cnt + 9'd1;
          en  <= 1'b0;
          if (cnt == {1'b0, nm1}) begin
            state <= RUN;
            pr    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= LOAD;
          end
        end
        default: begin
          state <= IDLE;
          pr    <= 1'b0;
          en    <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
          err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mas_prog_loader.sv
// Directed bench for mas_prog_loader: serial loads, header errors, sval gaps,
// mid-load reset, a full 256-word load and run-mode enable behaviour.
module tb_mas_prog_loader;

  logic        clk = 1'b0;
  logic        rstz, start, sdi, sval, run_en;
  wire         dvdd, dgnd;
  logic [15:0] instr;
  logic        pr, en, busy, done, err;
  logic [7:0]  wcnt;

  assign dvdd = 1'b1;
  assign dgnd = 1'b0;

  mas_prog_loader #(.SYNC(8'hA5)) dut (
    .clk(clk), .rstz(rstz), .dvdd(dvdd), .dgnd(dgnd),
    .start(start), .sdi(sdi), .sval(sval), .run_en(run_en),
    .instr(instr), .pr(pr), .en(en), .busy(busy), .done(done),
    .err(err), .wcnt(wcnt)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  // Write-pulse recorder, sampled mid-cycle.
  logic [15:0] pq[$];
  int unsigned pc[$];
  int unsigned stray = 0;
  always @(negedge clk) begin
    if (pr && en) begin
      pq.push_back(instr);
      pc.push_back(cyc);
    end
    if (busy && en && !pr) stray++;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bits(input logic [15:0] w, input int unsigned nbits, input int unsigned gap);
    for (int unsigned i = 0; i < nbits; i++) begin
      sdi  = w[15 - i];
      sval = 1'b1;
      @(posedge clk); #1;
      if (gap > 0) begin
        sval = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
      end
    end
    sval = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input int unsigned gap);
    send_bits(w, 16, gap);
  endtask

  task automatic start_load();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic settle();
    repeat (2) begin @(posedge clk); #1; end
  endtask

  int unsigned base;
  int unsigned s0;
  int          bad;
  logic [15:0] w;
  logic [7:0]  b;

  initial begin
    rstz = 1'b0; start = 1'b0; sdi = 1'b0; sval = 1'b0; run_en = 1'b0;
    #3;
    check("rst_pr", pr, 0);
    check("rst_en", en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_wcnt", wcnt, 0);
    check("rst_instr", instr, 0);
    #19 rstz = 1'b1;
    @(posedge clk); #1;

    // Three-word load, sval continuously high
    base = pq.size();
    start_load();
    check("t1_busy", busy, 1);
    send_word(16'hA502, 0);
    send_word(16'h1234, 0);
    send_word(16'h9C05, 0);
    send_word(16'hF0FF, 0);
    settle();
    check("t1_npulse", pq.size() - base, 3);
    check("t1_p0", pq[base], 16'h1234);
    check("t1_p1", pq[base + 1], 16'h9C05);
    check("t1_p2", pq[base + 2], 16'hF0FF);
    check("t1_gap01", pc[base + 1] - pc[base], 16);
    check("t1_gap12", pc[base + 2] - pc[base + 1], 16);
    check("t1_done", done, 1);
    check("t1_busy_end", busy, 0);
    check("t1_wcnt", wcnt, 3);
    check("t1_instr", instr, 16'hF0FF);
    check("t1_pr", pr, 0);
    check("t1_en", en, 0);

    // Bad header, then recovery
    base = pq.size();
    start_load();
    check("t2_busy", busy, 1);
    check("t2_done", done, 0);
    send_word(16'h5A00, 0);
    settle();
    check("t2_err", err, 1);
    check("t2_busy_err", busy, 0);
    check("t2_pr", pr, 0);
    check("t2_en", en, 0);
    check("t2_nopulse", pq.size() - base, 0);
    start_load();
    check("t2_err_clr", err, 0);
    check("t2_busy2", busy, 1);
    send_word(16'hA500, 0);
    send_word(16'hBEEF, 0);
    settle();
    check("t2_npulse", pq.size() - base, 1);
    check("t2_p0", pq[base], 16'hBEEF);
    check("t2_done2", done, 1);
    check("t2_wcnt", wcnt, 1);
    check("t2_err_end", err, 0);

    // Word delivered with sval gaps
    base = pq.size();
    start_load();
    send_word(16'hA500, 0);
    send_word(16'h6C3A, 2);
    settle();
    check("t3_npulse", pq.size() - base, 1);
    check("t3_p0", pq[base], 16'h6C3A);
    check("t3_done", done, 1);
    check("t3_wcnt", wcnt, 1);

    // Reset in the middle of the second word
    base = pq.size();
    start_load();
    send_word(16'hA503, 0);
    send_word(16'h1111, 0);
    send_bits(16'h2222, 8, 0);
    rstz = 1'b0;
    #1;
    check("t4_pr", pr, 0);
    check("t4_en", en, 0);
    check("t4_busy", busy, 0);
    check("t4_done", done, 0);
    check("t4_err", err, 0);
    check("t4_wcnt", wcnt, 0);
    check("t4_instr", instr, 0);
    check("t4_npulse_pre", pq.size() - base, 1);
    #2 rstz = 1'b1;
    @(posedge clk); #1;
    base = pq.size();
    start_load();
    send_word(16'hA503, 0);
    send_word(16'h0F1E, 0);
    send_word(16'h2D3C, 0);
    send_word(16'h4B5A, 0);
    send_word(16'h6978, 0);
    settle();
    check("t4_npulse", pq.size() - base, 4);
    check("t4_p0", pq[base], 16'h0F1E);
    check("t4_p3", pq[base + 3], 16'h6978);
    check("t4_wcnt_end", wcnt, 4);
    check("t4_done_end", done, 1);

    // 256-word load with start/run_en disturbances during loading
    base = pq.size();
    s0 = stray;
    start_load();
    send_word(16'hA5FF, 0);
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      if (i == 10) begin start = 1'b1; run_en = 1'b1; end
      send_word({b, ~b}, 0);
      if (i == 10) begin start = 1'b0; run_en = 1'b0; end
    end
    settle();
    check("t5_npulse", pq.size() - base, 256);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      w = {b, ~b};
      if (pq[base + i] !== w) bad++;
    end
    check("t5_vals", bad, 0);
    check("t5_wcnt", wcnt, 0);
    check("t5_done", done, 1);
    check("t5_busy", busy, 0);
    check("t5_stray_en", stray - s0, 0);

    // Run-mode enable follows run_en one cycle late; start reloads from RUN
    run_en = 1'b1;
    check("t6_en_lat0", en, 0);
    @(posedge clk); #1;
    check("t6_en_hi", en, 1);
    check("t6_pr_run", pr, 0);
    run_en = 1'b0;
    check("t6_en_lat1", en, 1);
    @(posedge clk); #1;
    check("t6_en_lo", en, 0);
    base = pq.size();
    start_load();
    check("t6_busy", busy, 1);
    check("t6_done", done, 0);
    send_word(16'hA501, 0);
    send_word(16'hCAFE, 0);
    send_word(16'h0001, 0);
    settle();
    check("t6_npulse", pq.size() - base, 2);
    check("t6_p0", pq[base], 16'hCAFE);
    check("t6_wcnt", wcnt, 2);
    check("t6_done_end", done, 1);
    check("t6_instr", instr, 16'h0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
